// File: rtl/bar_ctrl_pkg.sv
// bar_ctrl_pkg: shared types, opcodes and drain rule for the barrier controller
package bar_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, DRAIN, ICINV, FLUSH, DONE} bar_state_t;
  localparam logic [1:0] BAR_DBAR = 2'b01;
  localparam logic [1:0] BAR_IBAR = 2'b10;
  localparam logic [1:0] INVALID_OP_2B = 2'b11;
  localparam logic [15:0] BAR_OPCODE_HI = 16'h3872;
  localparam logic [1:0] BAR_HINT_FULL = 2'b00;
  localparam logic [1:0] BAR_HINT_ST = 2'b01;
  localparam logic [1:0] BAR_HINT_LD = 2'b10;
  function automatic logic is_bar(input logic [15:0] i_hi);
    return i_hi == BAR_OPCODE_HI;
  endfunction
  // A hinted DBAR may skip one of the two quiet conditions; everything else needs both.
  function automatic logic drain_ok(input logic i_ibar, input logic i_hint_en, input logic [1:0] i_hint,
                                    input logic i_zero, input logic i_sb_empty);
    logic w_sel;
    w_sel = i_hint_en & ~i_ibar;
    return (i_zero | (w_sel & i_hint == BAR_HINT_ST)) & (i_sb_empty | (w_sel & i_hint == BAR_HINT_LD));
  endfunction
endpackage

// File: rtl/bar_ctrl_outst_cnt.sv
// bar_outst_cnt: saturating outstanding-memory-op counter with zero and sticky error flags
module bar_outst_cnt
  import bar_ctrl_pkg::*;
#(
  parameter int OUTST_W = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_err
);
  logic [OUTST_W-1:0] r_cnt;
  logic               r_err;
  logic               w_max;
  assign w_max  = &r_cnt;
  assign o_zero = ~|r_cnt;
  assign o_err  = r_err;
  // Count in-flight ops; out-of-range steps hold the count and flag the error for good.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_inc & ~i_dec) begin
      if (w_max) r_err <= 1'b1;
      else r_cnt <= r_cnt + OUTST_W'(1);
    end else if (i_dec & ~i_inc) begin
      if (o_zero) r_err <= 1'b1;
      else r_cnt <= r_cnt - OUTST_W'(1);
    end
  end
endmodule

// File: rtl/bar_ctrl.sv
// bar_ctrl: DBAR/IBAR barrier sequencer that stalls issue until memory traffic drains
module bar_ctrl
  import bar_ctrl_pkg::*;
#(
  parameter int OUTST_W = 4,
  parameter bit HINT_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  input  logic [31:0] i_instr,
  output logic        o_in_ready,
  input  logic        i_mem_req_fire,
  input  logic        i_mem_resp_fire,
  input  logic        i_sb_empty,
  output logic        o_icache_inv_req,
  input  logic        i_icache_inv_ack,
  output logic        o_flush_req,
  output logic        o_bar_stall,
  output logic [1:0]  o_bar_op_type,
  output logic        o_bar_done,
  output logic        o_cnt_err
);
  bar_state_t r_state;
  logic [1:0] r_op;
  logic [1:0] r_hint;
  logic       r_inv_req;
  logic       r_flush;
  logic       r_done;
  logic       w_zero;
  logic       w_accept;
  logic       w_drained;
  logic       w_ibar;
  logic       w_unused_hint;
  bar_outst_cnt #(.OUTST_W(OUTST_W)) u_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (i_mem_req_fire),
    .i_dec  (i_mem_resp_fire),
    .o_zero (w_zero),
    .o_err  (o_cnt_err)
  );
  assign w_unused_hint    = &{1'b0, i_instr[14:2]};
  assign o_in_ready       = r_state == IDLE;
  assign o_bar_stall      = r_state != IDLE;
  assign w_accept         = i_in_valid & o_in_ready & is_bar(i_instr[31:16]);
  assign w_ibar           = r_op == BAR_IBAR;
  assign w_drained        = drain_ok(w_ibar, HINT_EN, r_hint, w_zero, i_sb_empty);
  assign o_icache_inv_req = r_inv_req;
  assign o_flush_req      = r_flush;
  assign o_bar_done       = r_done;
  assign o_bar_op_type    = r_op;
  // Barrier sequence; the request/pulse outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_op      <= INVALID_OP_2B;
      r_hint    <= BAR_HINT_FULL;
      r_inv_req <= 1'b0;
      r_flush   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_inv_req <= 1'b0;
      r_flush   <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= DRAIN;
          r_op    <= i_instr[15] ? BAR_IBAR : BAR_DBAR;
          r_hint  <= i_instr[1:0];
        end
        DRAIN: if (w_drained) begin
          r_state   <= w_ibar ? ICINV : DONE;
          r_inv_req <= w_ibar;
          r_done    <= ~w_ibar;
        end
        ICINV: if (i_icache_inv_ack) begin
          r_state <= FLUSH;
          r_flush <= 1'b1;
        end else r_inv_req <= 1'b1;
        FLUSH: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bar_ctrl.sv
// tb_bar_ctrl: three configurations driven in lockstep and checked against a behavioural model
module tb_bar_ctrl;
  import bar_ctrl_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, req, resp, sb_empty, ack;
  logic [31:0] instr;
  logic [2:0] rdy, inv, flush, stall, done, err;
  logic [1:0] opt [3];
  int n_cmp = 0;
  int n_bad = 0;
  int  m_phase [3];
  int  m_cnt [3];
  int  m_max [3] = '{15, 15, 3};
  bit  m_hen [3] = '{1'b1, 1'b0, 1'b1};
  bit  m_err [3];
  logic [1:0] m_op [3];
  logic [1:0] m_hint [3];

  bar_ctrl #(.OUTST_W(4), .HINT_EN(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_instr(instr), .o_in_ready(rdy[0]),
    .i_mem_req_fire(req), .i_mem_resp_fire(resp), .i_sb_empty(sb_empty), .o_icache_inv_req(inv[0]),
    .i_icache_inv_ack(ack), .o_flush_req(flush[0]), .o_bar_stall(stall[0]), .o_bar_op_type(opt[0]),
    .o_bar_done(done[0]), .o_cnt_err(err[0]));
  bar_ctrl #(.OUTST_W(4), .HINT_EN(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_instr(instr), .o_in_ready(rdy[1]),
    .i_mem_req_fire(req), .i_mem_resp_fire(resp), .i_sb_empty(sb_empty), .o_icache_inv_req(inv[1]),
    .i_icache_inv_ack(ack), .o_flush_req(flush[1]), .o_bar_stall(stall[1]), .o_bar_op_type(opt[1]),
    .o_bar_done(done[1]), .o_cnt_err(err[1]));
  bar_ctrl #(.OUTST_W(2), .HINT_EN(1'b1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_instr(instr), .o_in_ready(rdy[2]),
    .i_mem_req_fire(req), .i_mem_resp_fire(resp), .i_sb_empty(sb_empty), .o_icache_inv_req(inv[2]),
    .i_icache_inv_ack(ack), .o_flush_req(flush[2]), .o_bar_stall(stall[2]), .o_bar_op_type(opt[2]),
    .o_bar_done(done[2]), .o_cnt_err(err[2]));

  task automatic drive(input logic v, input logic [31:0] ins, input logic rq, input logic rs,
                       input logic sb, input logic ak);
    in_valid = v; instr = ins; req = rq; resp = rs; sb_empty = sb; ack = ak;
  endtask

  task automatic model_step();
    bit sel, wait_mem, wait_sb, drained;
    int nxt;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_phase[k] = 0; m_op[k] = INVALID_OP_2B; m_hint[k] = 2'b00; m_cnt[k] = 0; m_err[k] = 1'b0;
      end else begin
        sel = m_hen[k] && m_op[k] == BAR_DBAR;
        wait_mem = !(sel && m_hint[k] == 2'b01);
        wait_sb = !(sel && m_hint[k] == 2'b10);
        drained = (!wait_mem || m_cnt[k] == 0) && (!wait_sb || sb_empty);
        case (m_phase[k])
          0: if (in_valid && instr[31:16] == 16'h3872) begin
            m_phase[k] = 1;
            m_op[k] = instr[15] ? BAR_IBAR : BAR_DBAR;
            m_hint[k] = instr[1:0];
          end
          1: if (drained) m_phase[k] = (m_op[k] == BAR_IBAR) ? 2 : 4;
          2: if (ack) m_phase[k] = 3;
          3: m_phase[k] = 4;
          default: m_phase[k] = 0;
        endcase
        nxt = m_cnt[k] + int'(req) - int'(resp);
        if (nxt > m_max[k] || nxt < 0) m_err[k] = 1'b1;
        else m_cnt[k] = nxt;
      end
    end
  endtask

  task automatic check(input string tag, input int k, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] at %0t: got %0h expected %0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("in_ready", k, {1'b0, rdy[k]}, {1'b0, m_phase[k] == 0});
      check("bar_stall", k, {1'b0, stall[k]}, {1'b0, m_phase[k] != 0});
      check("icache_inv_req", k, {1'b0, inv[k]}, {1'b0, m_phase[k] == 2});
      check("flush_req", k, {1'b0, flush[k]}, {1'b0, m_phase[k] == 3});
      check("bar_done", k, {1'b0, done[k]}, {1'b0, m_phase[k] == 4});
      check("bar_op_type", k, opt[k], m_op[k]);
      check("cnt_err", k, {1'b0, err[k]}, {1'b0, m_err[k]});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0, 1, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    drive(1, 32'h3872_0000, 0, 0, 1, 0); cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (3) cyc();
    drive(0, 32'h0, 1, 0, 1, 0); repeat (3) cyc();
    drive(1, 32'h3872_0000, 0, 0, 1, 0); cyc();
    drive(0, 32'h0, 0, 0, 1, 0); cyc(); cyc();
    drive(0, 32'h0, 0, 1, 1, 0); cyc();
    drive(0, 32'h0, 1, 1, 1, 0); cyc();
    drive(0, 32'h0, 0, 1, 1, 0); cyc(); cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (3) cyc();
    drive(0, 32'h0, 1, 0, 1, 0); repeat (2) cyc();
    drive(1, 32'h3872_0001, 0, 0, 1, 0); cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (3) cyc();
    drive(0, 32'h0, 0, 1, 1, 0); repeat (2) cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (2) cyc();
    drive(1, 32'h3872_8000, 0, 0, 1, 0); cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (4) cyc();
    drive(0, 32'h0, 0, 0, 1, 1); cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (3) cyc();
    drive(1, 32'h3872_8002, 0, 0, 1, 0); cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (2) cyc();
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; cyc();
    drive(1, 32'h0000_0013, 0, 0, 1, 0); repeat (2) cyc();
    drive(1, 32'h3873_0000, 0, 0, 1, 0); cyc();
    drive(0, 32'h0, 1, 0, 1, 0); repeat (4) cyc();
    drive(0, 32'h0, 0, 1, 1, 0); repeat (5) cyc();
    drive(1, 32'h3872_0002, 0, 0, 0, 1); repeat (3) cyc();
    drive(0, 32'h0, 0, 0, 1, 0); repeat (3) cyc();
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(99) != 0;
      in_valid = $urandom_range(1) == 1;
      case ($urandom_range(3))
        0: instr = {16'h3872, 1'b0, 15'($urandom)};
        1: instr = {16'h3872, 1'b1, 15'($urandom)};
        2: instr = $urandom;
        default: instr = {16'h3873, 16'($urandom)};
      endcase
      req = $urandom_range(2) == 0;
      resp = $urandom_range(2) == 0;
      sb_empty = $urandom_range(3) != 0;
      ack = $urandom_range(2) == 0;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
